// File: rtl/rvv_vector_writeback_pkg.sv
// Purpose : shared types and constants for the vector writeback path (rvv_defs).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: vsew_e encoding, per-SEW element counts derived from VLEN, and
//           wb_entry_t, one buffered ALU result with everything the merge needs.
package rvv_defs;

  localparam int VLEN  = 512;
  localparam int VLENB = VLEN / 8;
  localparam int VLW   = $clog2(VLENB) + 1;

  // Elements per register for each SEW.
  localparam int ELEMS_E8  = VLENB;
  localparam int ELEMS_E16 = VLENB / 2;
  localparam int ELEMS_E32 = VLENB / 4;
  localparam int ELEMS_E64 = VLENB / 8;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEW64 = 2'b11
  } vsew_e;

  // Only the low VLENB bits of v0 can ever select an element (SEW=8 case),
  // so only those are carried through the buffer.
  typedef struct packed {
    logic [4:0]       vd;
    logic [VLEN-1:0]  data;
    logic [VLEN-1:0]  old;
    logic [VLENB-1:0] v0;
    logic             vm;
    vsew_e            vsew;
    logic [VLW-1:0]   vl;
    logic [VLW-1:0]   vstart;
    logic             vta;
    logic             vma;
  } wb_entry_t;

endpackage

// File: rtl/rvv_vector_writeback_if.sv
// Purpose : bundle of the writeback stage's channels: ALU result input
//           (valid/ready), load write input, flush, regfile write port, pending.
// Latency : n/a (wires only).
// Backpressure: in_ready on the ALU channel; the load channel has none.
// Modports: master = producer/consumer side (drives in_*, ld_*, flush);
//           slave  = writeback stage (drives in_ready, rd_*, pending).
interface rvv_vector_writeback_if #(
  parameter int VLEN = rvv_defs::VLEN,
  parameter int VLW  = $clog2(VLEN / 8) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_vd;
  logic [VLEN-1:0]  in_data;
  logic [VLEN-1:0]  in_old;
  logic [VLEN-1:0]  in_v0;
  logic             in_vm;
  logic [1:0]       in_vsew;
  logic [VLW-1:0]   in_vl;
  logic [VLW-1:0]   in_vstart;
  logic             in_vta;
  logic             in_vma;
  logic             ld_valid;
  logic [4:0]       ld_vd;
  logic [VLEN-1:0]  ld_data;
  logic             flush;
  logic             rd_we;
  logic [4:0]       rd_addr;
  logic [VLEN-1:0]  rd_data;
  logic [31:0]      pending;

  modport master (
    output in_valid, in_vd, in_data, in_old, in_v0, in_vm, in_vsew, in_vl,
           in_vstart, in_vta, in_vma, ld_valid, ld_vd, ld_data, flush,
    input  in_ready, rd_we, rd_addr, rd_data, pending
  );

  modport slave (
    input  in_valid, in_vd, in_data, in_old, in_v0, in_vm, in_vsew, in_vl,
           in_vstart, in_vta, in_vma, ld_valid, ld_vd, ld_data, flush,
    output in_ready, rd_we, rd_addr, rd_data, pending
  );
endinterface

// File: rtl/rvv_wb_mask_merge.sv
// Purpose : per-element merge of result data with old vd under RVV vstart/vl,
//           vm/v0 masking and tail/mask agnostic policy.
// Latency : combinational. Backpressure: none.
// Ports   : data/old/v0/vm/vsew/vl/vstart/vta/vma in, result out.
module rvv_wb_mask_merge
  import rvv_defs::*;
(
  input  logic [VLEN-1:0]  data,
  input  logic [VLEN-1:0]  old,
  input  logic [VLENB-1:0] v0,
  input  logic             vm,
  input  vsew_e            vsew,
  input  logic [VLW-1:0]   vl,
  input  logic [VLW-1:0]   vstart,
  input  logic             vta,
  input  logic             vma,
  output logic [VLEN-1:0]  result
);

  logic [VLW-1:0] nelem;
  logic [VLW-1:0] vl_eff;
  logic [VLW-1:0] idx;

  always_comb begin
    nelem = VLW'(ELEMS_E8);
    unique case (vsew)
      SEW8:  nelem = VLW'(ELEMS_E8);
      SEW16: nelem = VLW'(ELEMS_E16);
      SEW32: nelem = VLW'(ELEMS_E32);
      SEW64: nelem = VLW'(ELEMS_E64);
    endcase
    vl_eff = (vl > nelem) ? nelem : vl;
  end

  // Walk bytes; each byte inherits the class of the element it belongs to.
  // Prestart is tested first, so vstart >= vl leaves no body elements.
  always_comb begin
    result = old;
    idx    = '0;
    for (int b = 0; b < VLENB; b++) begin
      idx = VLW'(b) >> vsew;
      if (idx < vstart) begin
        result[8*b +: 8] = old[8*b +: 8];
      end else if (idx < vl_eff) begin
        if (vm || v0[idx[VLW-2:0]]) result[8*b +: 8] = data[8*b +: 8];
        else if (vma)               result[8*b +: 8] = 8'hFF;
      end else if (vta) begin
        result[8*b +: 8] = 8'hFF;
      end
    end
  end

endmodule

// File: rtl/rvv_vector_writeback.sv
// Purpose : vector writeback stage: buffers ALU results, masks/merges them and
//           drives one registered regfile write per cycle; loads take priority.
// Latency : ALU accept -> rd_we 2 cycles; load -> rd_we 1 cycle; 1 write/cycle.
// Backpressure: in_ready low when the FIFO is full or flush is asserted;
//           ALU head waits while a load owns the write port.
// Ports   : clk, rst (async, active-high), wb (slave modport of the bus).
module rvv_vector_writeback
  import rvv_defs::*;
#(
  parameter int VLEN  = rvv_defs::VLEN,
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst,
  rvv_vector_writeback_if.slave wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  wb_entry_t        in_ent;
  wb_entry_t        head;
  logic [VLEN-1:0]  merged;
  logic             unused_v0_hi;

  assign wb.in_ready = (count < CW'(DEPTH)) && !wb.flush;
  assign push        = wb.in_valid && wb.in_ready;
  // A load owns the port this cycle, and a flush discards rather than pops.
  assign pop         = !wb.ld_valid && (count != '0) && !wb.flush;
  assign head        = mem[rd_ptr];

  // v0 bits above VLENB never select an element.
  assign unused_v0_hi = ^wb.in_v0[VLEN-1:VLENB];

  always_comb begin
    in_ent        = '0;
    in_ent.vd     = wb.in_vd;
    in_ent.data   = wb.in_data;
    in_ent.old    = wb.in_old;
    in_ent.v0     = wb.in_v0[VLENB-1:0];
    in_ent.vm     = wb.in_vm;
    in_ent.vsew   = vsew_e'(wb.in_vsew);
    in_ent.vl     = wb.in_vl;
    in_ent.vstart = wb.in_vstart;
    in_ent.vta    = wb.in_vta;
    in_ent.vma    = wb.in_vma;
  end

  // Payload storage needs no reset; ent_vld/count qualify it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else if (wb.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        ent_vld[rd_ptr] <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  rvv_wb_mask_merge u_merge (
    .data   (head.data),
    .old    (head.old),
    .v0     (head.v0),
    .vm     (head.vm),
    .vsew   (head.vsew),
    .vl     (head.vl),
    .vstart (head.vstart),
    .vta    (head.vta),
    .vma    (head.vma),
    .result (merged)
  );

  // Idle cycles hold address/data so the port does not toggle needlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.rd_we   <= 1'b0;
      wb.rd_addr <= '0;
      wb.rd_data <= '0;
    end else if (wb.ld_valid) begin
      wb.rd_we   <= 1'b1;
      wb.rd_addr <= wb.ld_vd;
      wb.rd_data <= wb.ld_data;
    end else if (pop) begin
      wb.rd_we   <= 1'b1;
      wb.rd_addr <= head.vd;
      wb.rd_data <= merged;
    end else begin
      wb.rd_we   <= 1'b0;
    end
  end

  always_comb begin
    wb.pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[k]) wb.pending[mem[k].vd] = 1'b1;
    end
    if (wb.rd_we) wb.pending[wb.rd_addr] = 1'b1;
  end

endmodule

// File: tb/tb_rvv_vector_writeback.sv
// Purpose : directed self-checking bench for rvv_vector_writeback: table of
//           merge vectors with hand-computed results, plus load-priority,
//           flush and async-reset sequences.
// Ports   : none (top level); instantiates the bus interface and the DUT.
module tb_rvv_vector_writeback;
  localparam int VLEN = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rvv_vector_writeback_if #(.VLEN(VLEN)) wbif ();

  rvv_vector_writeback #(.VLEN(VLEN), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbif.slave)
  );

  typedef struct {
    logic [1:0]      vsew;
    logic [6:0]      vl;
    logic [6:0]      vstart;
    logic            vm;
    logic            vta;
    logic            vma;
    logic [63:0]     v0;
    logic [4:0]      vd;
    logic [VLEN-1:0] data;
    logic [VLEN-1:0] old;
    logic [VLEN-1:0] want;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    wbif.in_vd     = v.vd;
    wbif.in_data   = v.data;
    wbif.in_old    = v.old;
    wbif.in_v0     = {448'h0, v.v0};
    wbif.in_vm     = v.vm;
    wbif.in_vsew   = v.vsew;
    wbif.in_vl     = v.vl;
    wbif.in_vstart = v.vstart;
    wbif.in_vta    = v.vta;
    wbif.in_vma    = v.vma;
  endtask

  // Unmasked SEW=64 full-length write: result equals data.
  task automatic drive_plain(input logic [4:0] vd, input logic [VLEN-1:0] d);
    vec_t v;
    v = '{2'd3, 7'd8, 7'd0, 1'b1, 1'b0, 1'b0, 64'h0, vd, d, {VLEN{1'b0}}, d};
    drive_vec(v);
  endtask

  logic [4:0]      log_addr [$];
  logic [VLEN-1:0] log_data [$];
  int              nwr;

  initial begin
    vecs[0] = '{2'd2, 7'd16, 7'd0, 1'b1, 1'b0, 1'b0, 64'h0, 5'd3,
                {64{8'hA5}}, {VLEN{1'b0}}, {64{8'hA5}}};
    vecs[1] = '{2'd0, 7'd8, 7'd0, 1'b0, 1'b0, 1'b0, 64'h55, 5'd5,
                {64{8'hFF}}, {VLEN{1'b0}}, {448'h0, 64'h00FF00FF00FF00FF}};
    vecs[2] = '{2'd1, 7'd4, 7'd2, 1'b1, 1'b1, 1'b0, 64'h0, 5'd6,
                {32{16'h2222}}, {32{16'h1111}},
                {{28{16'hFFFF}}, 16'h2222, 16'h2222, 16'h1111, 16'h1111}};
    vecs[3] = '{2'd3, 7'd8, 7'd0, 1'b0, 1'b0, 1'b1, 64'h0F, 5'd7,
                {8{64'h0123456789ABCDEF}}, {VLEN{1'b0}},
                {{4{64'hFFFFFFFFFFFFFFFF}}, {4{64'h0123456789ABCDEF}}}};
    vecs[4] = '{2'd2, 7'd64, 7'd0, 1'b1, 1'b0, 1'b0, 64'h0, 5'd8,
                {16{32'hDEADBEEF}}, {16{32'h5A5A5A5A}}, {16{32'hDEADBEEF}}};
    vecs[5] = '{2'd0, 7'd5, 7'd10, 1'b1, 1'b0, 1'b0, 64'h0, 5'd9,
                {VLEN{1'b0}}, {64{8'h3C}}, {64{8'h3C}}};
    vecs[6] = '{2'd2, 7'd3, 7'd0, 1'b0, 1'b0, 1'b0, 64'hFF, 5'd12,
                {16{32'hCAFEF00D}}, {16{32'h12345678}},
                {{13{32'h12345678}}, {3{32'hCAFEF00D}}}};
    vecs[7] = '{2'd3, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0, 64'h0, 5'd31,
                {8{64'h0123456789ABCDEF}}, {VLEN{1'b0}}, {VLEN{1'b1}}};

    wbif.in_valid = 1'b0;
    wbif.ld_valid = 1'b0;
    wbif.ld_vd    = '0;
    wbif.ld_data  = '0;
    wbif.flush    = 1'b0;
    drive_plain(5'd0, {VLEN{1'b0}});

    // Reset values, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_rd_we", wbif.rd_we, 0);
    chk("rst_rd_addr", wbif.rd_addr, 0);
    chk("rst_rd_data", wbif.rd_data, 0);
    chk("rst_pending", wbif.pending, 0);
    chk("rst_in_ready", wbif.in_ready, 1);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // Table: accept in cycle N, write in N+2, pending over N+1..N+2.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive_vec(vecs[i]);
      wbif.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), wbif.in_ready, 1);
      @(posedge clk); #1 wbif.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_we_n1", i), wbif.rd_we, 0);
      chk($sformatf("v%0d_pend_n1", i), wbif.pending, 32'(1) << vecs[i].vd);
      @(negedge clk);
      chk($sformatf("v%0d_we_n2", i), wbif.rd_we, 1);
      chk($sformatf("v%0d_addr", i), wbif.rd_addr, vecs[i].vd);
      chk($sformatf("v%0d_data", i), wbif.rd_data, vecs[i].want);
      chk($sformatf("v%0d_pend_n2", i), wbif.pending, 32'(1) << vecs[i].vd);
      @(negedge clk);
      chk($sformatf("v%0d_we_n3", i), wbif.rd_we, 0);
      chk($sformatf("v%0d_pend_n3", i), wbif.pending, 0);
    end

    // Load priority: ALU vd=1, then ALU vd=2 together with load vd=9.
    @(posedge clk); #1;
    drive_plain(5'd1, {64{8'h01}});
    wbif.in_valid = 1'b1;
    @(posedge clk); #1;
    drive_plain(5'd2, {64{8'h02}});
    wbif.ld_valid = 1'b1;
    wbif.ld_vd    = 5'd9;
    wbif.ld_data  = {64{8'h99}};
    @(posedge clk); #1;
    wbif.in_valid = 1'b0;
    wbif.ld_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) chk("lp_full_in_ready", wbif.in_ready, 0);
      if (k == 1) chk("lp_recover_in_ready", wbif.in_ready, 1);
      if (wbif.rd_we) begin
        log_addr.push_back(wbif.rd_addr);
        log_data.push_back(wbif.rd_data);
      end
    end
    chk("lp_nwrites", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("lp_order0", log_addr[0], 9);
      chk("lp_order1", log_addr[1], 1);
      chk("lp_order2", log_addr[2], 2);
      chk("lp_data0", log_data[0], {64{8'h99}});
      chk("lp_data1", log_data[1], {64{8'h01}});
      chk("lp_data2", log_data[2], {64{8'h02}});
    end

    // Flush: two queued (4 stalled behind load 7), 4 in flight, then flush
    // with 5 still buffered. Request vd=8 while full/flushing must be ignored.
    @(posedge clk); #1;
    drive_plain(5'd4, {64{8'h44}});
    wbif.in_valid = 1'b1;
    @(posedge clk); #1;
    drive_plain(5'd5, {64{8'h55}});
    wbif.ld_valid = 1'b1;
    wbif.ld_vd    = 5'd7;
    @(posedge clk); #1;
    drive_plain(5'd8, {64{8'h88}});
    wbif.ld_valid = 1'b0;
    @(negedge clk);
    chk("fl_full_in_ready", wbif.in_ready, 0);
    chk("fl_ld_addr", wbif.rd_addr, 7);
    @(posedge clk); #1 wbif.flush = 1'b1;
    @(negedge clk);
    chk("fl_inflight_we", wbif.rd_we, 1);
    chk("fl_inflight_addr", wbif.rd_addr, 4);
    chk("fl_inflight_data", wbif.rd_data, {64{8'h44}});
    chk("fl_pend_during", wbif.pending, (32'(1) << 4) | (32'(1) << 5));
    chk("fl_in_ready_during", wbif.in_ready, 0);
    @(posedge clk); #1;
    wbif.flush    = 1'b0;
    wbif.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_in_ready_after", wbif.in_ready, 1);
    chk("fl_pend_after", wbif.pending, 0);
    nwr = 0;
    for (int k = 0; k < 5; k++) begin
      if (wbif.rd_we) nwr++;
      @(negedge clk);
    end
    chk("fl_no_writes", nwr, 0);

    // Async reset mid-burst: two buffered, load on the port.
    @(posedge clk); #1;
    drive_plain(5'd10, {64{8'hAA}});
    wbif.in_valid = 1'b1;
    wbif.ld_valid = 1'b1;
    wbif.ld_vd    = 5'd11;
    @(posedge clk); #1;
    drive_plain(5'd12, {64{8'hCC}});
    @(posedge clk); #1;
    wbif.in_valid = 1'b0;
    wbif.ld_valid = 1'b0;
    @(negedge clk);
    chk("ar_busy_pend", wbif.pending, (32'(1) << 10) | (32'(1) << 11) | (32'(1) << 12));
    #2 rst = 1'b1;
    #1;
    chk("ar_rd_we", wbif.rd_we, 0);
    chk("ar_pending", wbif.pending, 0);
    chk("ar_in_ready", wbif.in_ready, 1);
    chk("ar_rd_addr", wbif.rd_addr, 0);
    @(negedge clk); #2 rst = 1'b0;
    nwr = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wbif.rd_we || (wbif.pending != 0)) nwr++;
    end
    chk("ar_quiet_after", nwr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
